// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bus: hazard inputs from ID/EX/MEM and the stall/valid
// controls driven back into the pipeline registers.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             if_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_resp;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             stall_wb;
  logic             v_id;
  logic             v_ex;
  logic             v_mem;
  logic             v_wb;
  logic             dmem_start;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline / memory side
  modport master (
    output if_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_is_load, ex_redirect, mem_req, mem_resp,
    input  stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           v_id, v_ex, v_mem, v_wb, dmem_start, mem_err, stall_cnt
  );

  // Controller side
  modport slave (
    input  if_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_is_load, ex_redirect, mem_req, mem_resp,
    output stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           v_id, v_ex, v_mem, v_wb, dmem_start, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage valids,
// stall generation, load-use detection, redirect squash and the dmem handshake.
module pipe_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_if.slave     bus
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  mem_state_t       mem_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             v_id_q;
  logic             v_ex_q;
  logic             v_mem_q;
  logic             v_wb_q;

  logic             rs1_hit;
  logic             rs2_hit;
  logic             mem_hold;
  logic             load_use;
  logic             redirect;
  logic             dmem_start;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;

  // Hazard terms; gated by reset so nothing leaks while the valids clear
  always_comb begin
    rs1_hit    = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
    rs2_hit    = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
    mem_hold   = !reset && v_mem_q && bus.mem_req
                 && !((mem_state == M_WAIT) && bus.mem_resp);
    load_use   = !reset && v_ex_q && bus.ex_is_load && (bus.ex_rd != 5'd0)
                 && v_id_q && (rs1_hit || rs2_hit);
    redirect   = !reset && v_ex_q && bus.ex_redirect && !mem_hold;
    dmem_start = !reset && (mem_state == M_IDLE) && v_mem_q && bus.mem_req;
  end

  // Stall fan-out in priority order: memory hold, redirect, load-use
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    if (mem_hold) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (!redirect && load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
    end
  end

  // Stage valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
    end else if (mem_hold) begin
      v_wb_q  <= 1'b0;
    end else if (redirect) begin
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b1;
      v_wb_q  <= v_mem_q;
    end else if (load_use) begin
      v_ex_q  <= 1'b0;
      v_mem_q <= v_ex_q;
      v_wb_q  <= v_mem_q;
    end else begin
      v_id_q  <= bus.if_valid;
      v_ex_q  <= v_id_q;
      v_mem_q <= v_ex_q;
      v_wb_q  <= v_mem_q;
    end
  end

  // Data-memory handshake FSM with sticky timeout; the wait continues past timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state <= M_IDLE;
      tmo_cnt   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (mem_state)
        M_IDLE: begin
          if (dmem_start) begin
            mem_state <= M_WAIT;
            tmo_cnt   <= '0;
          end
        end
        M_WAIT: begin
          if (tmo_cnt != TMO_W'(MEM_TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
          if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
            mem_err_q <= 1'b1;
          end
          if (bus.mem_resp) begin
            mem_state <= M_IDLE;
          end
        end
        default: mem_state <= M_IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((mem_hold || load_use) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_if   = stall_if;
  assign bus.stall_id   = stall_id;
  assign bus.stall_ex   = stall_ex;
  assign bus.stall_mem  = stall_mem;
  assign bus.stall_wb   = 1'b0;
  assign bus.v_id       = v_id_q;
  assign bus.v_ex       = v_ex_q;
  assign bus.v_mem      = v_mem_q;
  assign bus.v_wb       = v_wb_q;
  assign bus.dmem_start = dmem_start;
  assign bus.mem_err    = mem_err_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle pushes the expected output snapshot
// and pops it against the DUT one time unit after the inputs settle.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(.CNT_W(32), .MEM_TIMEOUT(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [4:0]  st;
    logic [3:0]  v;
    logic [1:0]  fl;
    logic [31:0] cnt;
    bit          chk_err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic drv(input logic ifv, input logic ld, input logic [4:0] rd,
                     input logic redir, input logic u1, input logic [4:0] rs1,
                     input logic u2, input logic [4:0] rs2,
                     input logic req, input logic resp);
    bus.if_valid    = ifv;
    bus.ex_is_load  = ld;
    bus.ex_rd       = rd;
    bus.ex_redirect = redir;
    bus.id_uses_rs1 = u1;
    bus.id_rs1      = rs1;
    bus.id_uses_rs2 = u2;
    bus.id_rs2      = rs2;
    bus.mem_req     = req;
    bus.mem_resp    = resp;
  endtask

  // st={if,id,ex,mem,wb}, v={id,ex,mem,wb}, fl={dmem_start,mem_err}
  task automatic cyc(input string tag, input logic [4:0] st, input logic [3:0] v,
                     input logic [1:0] fl, input logic [31:0] cnt, input bit chk_err);
    exp_t       e;
    logic [4:0] o_st;
    logic [3:0] o_v;
    logic [1:0] o_fl;
    logic [1:0] msk;
    e.tag = tag; e.st = st; e.v = v; e.fl = fl; e.cnt = cnt; e.chk_err = chk_err;
    sb.push_back(e);
    #1;
    e    = sb.pop_front();
    o_st = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.stall_wb};
    o_v  = {bus.v_id, bus.v_ex, bus.v_mem, bus.v_wb};
    o_fl = {bus.dmem_start, bus.mem_err};
    msk  = e.chk_err ? 2'b11 : 2'b10;
    checks++;
    assert (o_st === e.st) else begin
      failures++;
      $error("FAIL %s stalls obs=%b exp=%b", e.tag, o_st, e.st);
    end
    checks++;
    assert (o_v === e.v) else begin
      failures++;
      $error("FAIL %s valids obs=%b exp=%b", e.tag, o_v, e.v);
    end
    checks++;
    assert ((o_fl & msk) === (e.fl & msk)) else begin
      failures++;
      $error("FAIL %s start_err obs=%b exp=%b", e.tag, o_fl, e.fl);
    end
    checks++;
    assert (bus.stall_cnt === e.cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt obs=%0d exp=%0d", e.tag, bus.stall_cnt, e.cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc("rst0", 5'b00000, 4'b0000, 2'b00, 0, 1);
    cyc("rst1", 5'b00000, 4'b0000, 2'b00, 0, 1);
    reset = 1'b0;

    // Fill with no hazards
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("fill0", 5'b00000, 4'b0000, 2'b00, 0, 1);
    cyc("fill1", 5'b00000, 4'b1000, 2'b00, 0, 1);
    cyc("fill2", 5'b00000, 4'b1100, 2'b00, 0, 1);
    cyc("fill3", 5'b00000, 4'b1110, 2'b00, 0, 1);
    cyc("fill4", 5'b00000, 4'b1111, 2'b00, 0, 1);

    // Load-use on rs2, x0 destination, rs1 hit, unused-operand match
    drv(1, 1, 5, 0, 0, 0, 1, 5, 0, 0);
    cyc("lu_rs2", 5'b11000, 4'b1111, 2'b00, 0, 1);
    drv(1, 0, 5, 0, 0, 0, 1, 5, 0, 0);
    cyc("lu_bub", 5'b00000, 4'b1011, 2'b00, 1, 1);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("lu_x0", 5'b00000, 4'b1101, 2'b00, 1, 1);
    drv(1, 1, 7, 0, 1, 7, 0, 0, 0, 0);
    cyc("lu_rs1", 5'b11000, 4'b1110, 2'b00, 1, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_aft", 5'b00000, 4'b1011, 2'b00, 2, 1);
    drv(1, 1, 9, 0, 0, 9, 0, 9, 0, 0);
    cyc("lu_nouse", 5'b00000, 4'b1101, 2'b00, 2, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("pre_mem", 5'b00000, 4'b1110, 2'b00, 2, 1);

    // Memory op answered 3 cycles after start
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mem_st", 5'b11110, 4'b1111, 2'b10, 2, 1);
    cyc("mem_w1", 5'b11110, 4'b1110, 2'b00, 3, 1);
    cyc("mem_w2", 5'b11110, 4'b1110, 2'b00, 4, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("mem_rsp", 5'b00000, 4'b1110, 2'b00, 5, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mem_aft", 5'b00000, 4'b1111, 2'b00, 5, 1);

    // Redirect squash, then redirect held behind a memory op
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("redir", 5'b00000, 4'b1111, 2'b00, 5, 1);
    cyc("redir_sq", 5'b00000, 4'b0011, 2'b00, 5, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("refill1", 5'b00000, 4'b1001, 2'b00, 5, 1);
    cyc("refill2", 5'b00000, 4'b1100, 2'b00, 5, 1);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("rmh_st", 5'b11110, 4'b1110, 2'b10, 5, 1);
    cyc("rmh_w", 5'b11110, 4'b1110, 2'b00, 6, 1);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    cyc("rmh_rsp", 5'b00000, 4'b1110, 2'b00, 7, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rmh_sq", 5'b00000, 4'b0011, 2'b00, 7, 1);
    cyc("refill3", 5'b00000, 4'b1001, 2'b00, 7, 1);
    cyc("refill4", 5'b00000, 4'b1100, 2'b00, 7, 1);

    // Timeout: response withheld well past MEM_TIMEOUT cycles
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("tmo_st", 5'b11110, 4'b1110, 2'b10, 7, 1);
    for (int j = 1; j <= 1030; j++) begin
      cyc("tmo_w", 5'b11110, 4'b1110, (j > 1024) ? 2'b01 : 2'b00,
          32'(7 + j), j != 1025);
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("tmo_rsp", 5'b00000, 4'b1110, 2'b01, 1038, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("tmo_aft", 5'b00000, 4'b1111, 2'b01, 1038, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("tmo_idle", 5'b11110, 4'b1111, 2'b11, 1038, 1);
    cyc("tmo_w2", 5'b11110, 4'b1110, 2'b01, 1039, 1);

    // Reset while waiting, then a stale response
    reset = 1'b1;
    cyc("rst_wait", 5'b00000, 4'b0000, 2'b00, 0, 1);
    reset = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("late_rsp", 5'b00000, 4'b0000, 2'b00, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post1", 5'b00000, 4'b1000, 2'b00, 0, 1);
    cyc("post2", 5'b00000, 4'b1100, 2'b00, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("post_st", 5'b11110, 4'b1110, 2'b10, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("post_rsp", 5'b00000, 4'b1110, 2'b00, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV64 pipeline.
- Owns the valid bit of each stage (ID, EX, MEM, WB).
- Drives the per-stage stall inputs of the ID/EX/MEM/WB pipeline registers plus the fetch PC hold.
- Runs the MEM-stage data-memory request/response handshake.
- Detects load-use hazards and squashes wrong-path instructions on an EX redirect.

Parameters:
- CNT_W, 32: width of the stall-cycle performance counter.
- MEM_TIMEOUT, 1024: cycles in M_WAIT before mem_err is raised.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents a valid instruction to ID this cycle.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM instruction needs data memory (load/store).
- mem_resp  in  1  data memory completes the outstanding request.
- stall_if  out  1  hold PC and fetch.
- stall_id  out  1  ID register holds.
- stall_ex  out  1  EX register holds.
- stall_mem  out  1  MEM register holds.
- stall_wb  out  1  WB register holds; always 0.
- v_id  out  1  valid of the ID stage.
- v_ex  out  1  valid of the EX stage.
- v_mem  out  1  valid of the MEM stage.
- v_wb  out  1  valid of the WB stage; WB writes back only when set.
- dmem_start  out  1  one-cycle pulse that launches a data-memory request.
- mem_err  out  1  sticky flag: memory timeout.
- stall_cnt  out  CNT_W  count of stall cycles.

Behaviour:
Reset:
- Async reset forces v_* = 0, FSM = M_IDLE, timeout counter = 0, stall_cnt = 0, mem_err = 0.
- Combinational outputs evaluate to 0 under reset.
- Reset mid-request abandons the request; a late mem_resp arriving in M_IDLE is ignored.

Memory FSM (states M_IDLE, M_WAIT):
- dmem_start = (M_IDLE && v_mem && mem_req).
- M_IDLE -> M_WAIT on dmem_start.
- M_WAIT -> M_IDLE on mem_resp.
- Timeout counter clears on entering M_WAIT and increments each cycle in M_WAIT.
- Counter reaching MEM_TIMEOUT sets mem_err (sticky until reset). The FSM keeps waiting.

Hazard terms (combinational):
- mem_hold = v_mem && mem_req && !(M_WAIT && mem_resp). Minimum memory op = 2 cycles in MEM (start cycle, then response cycle).
- load_use = v_ex && ex_is_load && ex_rd != 0 && v_id && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- redirect = v_ex && ex_redirect && !mem_hold.

Per-cycle actions, in strict priority order:
1. mem_hold:
   - stall_if = stall_id = stall_ex = stall_mem = 1.
   - v_id, v_ex, v_mem hold; v_wb <= 0 (bubble into WB).
   - A pending redirect stays pending because EX is frozen.
2. redirect:
   - No stalls.
   - v_id <= 0, v_ex <= 0 (squash the two younger instructions).
   - v_mem <= 1, v_wb <= v_mem.
   - Fetch takes the target; that instruction is accepted next cycle via if_valid.
3. load_use:
   - stall_if = stall_id = 1.
   - v_ex <= 0 (bubble), v_mem <= v_ex, v_wb <= v_mem.
4. Normal advance:
   - v_id <= if_valid, v_ex <= v_id, v_mem <= v_ex, v_wb <= v_mem.

Other rules:
- stall_wb is constantly 0.
- Stall outputs are combinational from current state and inputs (same cycle).
- stall_cnt increments on cycles with mem_hold || load_use and saturates at all-ones.
- redirect and load_use cannot both be true from a single EX instruction (loads never redirect). If both inputs appear, redirect wins.

Test Plan:
- Reset then if_valid=1 for 4 cycles, no hazards -> v_id..v_wb become 1 on successive cycles; all stalls 0; stall_cnt=0.
- Load in EX with ex_rd=5; ID uses rs2=5 -> 1 cycle with stall_if=stall_id=1; next cycle v_ex=0 with ID unchanged; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Load reaches MEM, mem_resp 3 cycles after dmem_start -> dmem_start high exactly 1 cycle; stall_mem high 3 cycles; v_wb=0 those cycles; stall_cnt=3.
- ex_redirect with v_id=v_ex=1 -> next cycle v_id=0, v_ex=0, v_mem=1; redirect asserted during mem_hold -> squash delayed until the cycle mem_resp arrives.
- mem_resp withheld for MEM_TIMEOUT cycles -> mem_err=1 and stays 1; later mem_resp returns the FSM to M_IDLE.
- Assert reset while in M_WAIT, release, then pulse mem_resp -> FSM stays M_IDLE; all v_*=0; no dmem_start.
